icache_assoc: RTL and testbench

ICACHE_ASSOC -- requirements
Module: icache_assoc

---
 rtl/icache_assoc.sv | 186 ++++++++++++++++++
 tb/tb_icache_assoc.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache. The lookup result is
// available one cycle after a request is accepted. A miss fetches the whole
// line through a refill handshake, then replays the original request.
//
// Ports
//   clock, reset_n            rising-edge clock, async active-low reset
//   mmu_enabled, mode         translation context, stored as part of the tag
//   req_valid/req_ready       fetch request handshake
//   req_vaddr                 word address, vaddr[VLEN-1:2]
//   resp_valid/resp_word      hit response, instruction bits [31:2]
//   refill_req/refill_addr    line fill request; stays stable until ack
//   refill_ack/refill_data    line contents, valid on the ack cycle
//   invalidate                clears every valid bit in one cycle
//   hit_count/miss_count      demand lookup counters (ICACHE_ASSOC_PERF_EN)
//
// Optional feature: define ICACHE_ASSOC_PERF_EN to add the saturating
// hit/miss counters and their ports.
module icache_assoc #(
   parameter  int WAYS       = 2,
   parameter  int SETS_LOG2  = 8,
   parameter  int LINE_WORDS = 8,
   parameter  int VLEN       = 39,
   localparam int OFS        = $clog2(LINE_WORDS*4)
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    mmu_enabled,
   input  logic [1:0]              mode,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [VLEN-3:0]         req_vaddr,
   output logic                    resp_valid,
   output logic [29:0]             resp_word,
   output logic                    refill_req,
   output logic [VLEN-OFS-1:0]     refill_addr,
   input  logic                    refill_ack,
   input  logic [LINE_WORDS*32-1:0] refill_data,
   input  logic                    invalidate
`ifdef ICACHE_ASSOC_PERF_EN
   ,
   output logic [31:0]             hit_count,
   output logic [31:0]             miss_count
`endif
);
   localparam int SETS  = 1 << SETS_LOG2;
   localparam int WB    = OFS - 2;
   localparam int TAG_W = VLEN - OFS - SETS_LOG2;
   localparam int WAYW  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REQ, S_FILL, S_BUBBLE, S_REPLAY} state_t;

   typedef struct packed {
      logic [VLEN-3:0] addr;
      logic [1:0]      mode;
      logic            mmu;
   } lk_t;

   state_t state_q, state_d;
   lk_t    lk_q, lk_d;
   logic   rdy_q, replay_q;

   logic [TAG_W-1:0] tag_q   [SETS][WAYS];
   logic [1:0]       tmode_q [SETS][WAYS];
   logic             tmmu_q  [SETS][WAYS];
   logic [29:0]      data_q  [SETS][WAYS][LINE_WORDS];
   logic [WAYS-1:0]  valid_q [SETS];
   logic [WAYW-1:0]  rr_q    [SETS];

   logic [SETS_LOG2-1:0] set_idx;
   logic [TAG_W-1:0]     tag;
   logic [WB-1:0]        word;
   logic [WAYS-1:0]      hit_way;
   logic [29:0]          hit_word;
   logic                 hit, accept, fill_en;
   logic [WAYW-1:0]      fill_way;
   logic [29:0]          fill_words [LINE_WORDS];

   assign set_idx = lk_q.addr[WB +: SETS_LOG2];
   assign tag     = lk_q.addr[VLEN-3 -: TAG_W];
   assign word    = lk_q.addr[WB-1:0];

   // Tag compare and one-hot data select; at most one way can match.
   always_comb begin
      hit_way  = '0;
      hit_word = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag &&
             tmode_q[set_idx][w] == lk_q.mode && tmmu_q[set_idx][w] == lk_q.mmu) begin
            hit_way[w] = 1'b1;
            hit_word   = hit_word | data_q[set_idx][w][word];
         end
      end
   end
   assign hit = |hit_way;

   // Lowest invalid way wins; with a full set fall back to round-robin.
   always_comb begin
      fill_way = rr_q[set_idx];
      for (int w = WAYS-1; w >= 0; w--)
         if (!valid_q[set_idx][w]) fill_way = WAYW'(w);
   end

   // Anything that is not a 32-bit encoding becomes an illegal instruction.
   always_comb begin
      for (int i = 0; i < LINE_WORDS; i++)
         fill_words[i] = (refill_data[i*32 +: 2] == 2'b11) ? refill_data[i*32+2 +: 30]
                                                           : 30'h3FFFFFFF;
   end

   assign req_ready   = rdy_q && (state_q == S_IDLE || (state_q == S_LOOKUP && hit));
   assign accept      = req_valid && req_ready;
   assign resp_valid  = (state_q == S_LOOKUP) && hit;
   assign resp_word   = hit_word;
   assign refill_req  = (state_q == S_REQ);
   assign refill_addr = lk_q.addr[VLEN-3:WB];

   // S_FILL is never entered: the line is written on the ack cycle itself.
   always_comb begin
      state_d = state_q;
      lk_d    = lk_q;
      fill_en = 1'b0;
      unique case (state_q)
         S_IDLE:   if (accept) state_d = S_LOOKUP;
         S_LOOKUP: state_d = !hit ? S_REQ : (accept ? S_LOOKUP : S_IDLE);
         S_REQ:    if (refill_ack) begin
                      fill_en = 1'b1;
                      state_d = S_BUBBLE;
                   end
         S_BUBBLE: state_d = S_REPLAY;
         S_REPLAY: state_d = S_LOOKUP;
         default:  state_d = S_IDLE;
      endcase
      if (accept) lk_d = '{addr: req_vaddr, mode: mode, mmu: mmu_enabled};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         lk_q     <= '0;
         rdy_q    <= 1'b0;
         replay_q <= 1'b0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            rr_q[s]    <= '0;
         end
      end else begin
         state_q  <= state_d;
         lk_q     <= lk_d;
         rdy_q    <= 1'b1;
         replay_q <= (state_q == S_REPLAY);
         if (invalidate) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
         end else if (fill_en) begin
            valid_q[set_idx][fill_way] <= 1'b1;
            rr_q[set_idx] <= (WAYS == 1) ? '0 : rr_q[set_idx] + 1'b1;
         end
      end
   end

   // Tag and data arrays carry no reset; valid bits guard them.
   always_ff @(posedge clock) begin
      if (fill_en && !invalidate) begin
         tag_q[set_idx][fill_way]   <= tag;
         tmode_q[set_idx][fill_way] <= lk_q.mode;
         tmmu_q[set_idx][fill_way]  <= lk_q.mmu;
         for (int i = 0; i < LINE_WORDS; i++)
            data_q[set_idx][fill_way][i] <= fill_words[i];
      end
   end

`ifdef ICACHE_ASSOC_PERF_EN
   // Only demand lookups count; the lookup following a replay is skipped.
   logic [31:0] hit_q, miss_q;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else if (state_q == S_LOOKUP && !replay_q) begin
         if (hit && hit_q != 32'hFFFFFFFF)   hit_q  <= hit_q + 1'b1;
         if (!hit && miss_q != 32'hFFFFFFFF) miss_q <= miss_q + 1'b1;
      end
   end
   assign hit_count  = hit_q;
   assign miss_count = miss_q;
`endif
endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc at default parameters (2 ways, 256 sets,
// 8-word lines, VLEN 39): cold miss, streaming hits, replacement, illegal
// word conversion, invalidate/fill collision and reset during refill.
module tb_icache_assoc;
   logic         clock = 1'b0;
   logic         reset_n;
   logic         mmu_enabled;
   logic [1:0]   mode;
   logic         req_valid;
   logic         req_ready;
   logic [36:0]  req_vaddr;
   logic         resp_valid;
   logic [29:0]  resp_word;
   logic         refill_req;
   logic [33:0]  refill_addr;
   logic         refill_ack;
   logic [255:0] refill_data;
   logic         invalidate;
`ifdef ICACHE_ASSOC_PERF_EN
   logic [31:0]  hit_count, miss_count;
`endif

   int nvec = 0;
   int nerr = 0;

   icache_assoc dut (
      .clock(clock), .reset_n(reset_n), .mmu_enabled(mmu_enabled), .mode(mode),
      .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
      .resp_valid(resp_valid), .resp_word(resp_word),
      .refill_req(refill_req), .refill_addr(refill_addr),
      .refill_ack(refill_ack), .refill_data(refill_data), .invalidate(invalidate)
`ifdef ICACHE_ASSOC_PERF_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Word i of line k: 32-bit encoding, distinct per line and per word.
   function automatic logic [31:0] wd(input int k, input int i);
      return 32'h13 | (32'(k) << 8) | (32'(i) << 20);
   endfunction

   function automatic logic [255:0] mkline(input int k);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = wd(k, i);
      return l;
   endfunction

   // Miss, refill and replay; the response lands 3 cycles after the ack.
   task automatic miss_fill(input string nm, input logic [36:0] a,
                            input logic [255:0] line, input logic [29:0] expw);
      req_valid = 1'b1; req_vaddr = a;
      step();
      req_valid = 1'b0;
      chk({nm, ".miss"}, resp_valid, 0);
      step();
      chk({nm, ".rreq"}, refill_req, 1);
      chk({nm, ".raddr"}, refill_addr, a >> 3);
      refill_ack = 1'b1; refill_data = line;
      step();
      refill_ack = 1'b0;
      chk({nm, ".bubble"}, resp_valid, 0);
      step();
      chk({nm, ".replay"}, resp_valid, 0);
      step();
      chk({nm, ".rv"}, resp_valid, 1);
      chk({nm, ".word"}, resp_word, expw);
      step();
   endtask

   task automatic hit_chk(input string nm, input logic [36:0] a, input logic [29:0] expw);
      req_valid = 1'b1; req_vaddr = a;
      step();
      req_valid = 1'b0;
      chk({nm, ".rv"}, resp_valid, 1);
      chk({nm, ".word"}, resp_word, expw);
      step();
   endtask

   initial begin
      logic [255:0] cl;
      reset_n = 1'b0; mmu_enabled = 1'b1; mode = 2'd3; req_valid = 1'b0;
      req_vaddr = '0; refill_ack = 1'b0; refill_data = '0; invalidate = 1'b0;
      step(); step();
      chk("rst.ready", req_ready, 0);
      chk("rst.resp", resp_valid, 0);
      chk("rst.rreq", refill_req, 0);
      reset_n = 1'b1;
      step();
      chk("rst.ready_after", req_ready, 1);

      // Cold miss at byte 0x1000, then stream the whole line.
      miss_fill("cold", 37'h400, mkline(0), 30'(wd(0, 0) >> 2));
      req_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("stream%0d.ready", i), req_ready, 1);
         req_vaddr = 37'h400 + 37'(i);
         step();
         chk($sformatf("stream%0d.rv", i), resp_valid, 1);
         chk($sformatf("stream%0d.word", i), resp_word, 30'(wd(0, i) >> 2));
      end
      req_valid = 1'b0;
      step();
`ifdef ICACHE_ASSOC_PERF_EN
      chk("perf.hits", hit_count, 8);
      chk("perf.miss", miss_count, 1);
`endif

      // Non-32-bit word 2 becomes the illegal pattern; word 0 is untouched.
      cl = mkline(0);
      cl[2*32 +: 32] = 32'h00004501;
      miss_fill("cmp", 37'h802, cl, 30'h3FFFFFFF);
      hit_chk("cmp.w0", 37'h800, 30'(wd(0, 0) >> 2));

      // Set 5, tags 1..4: C evicts A, D evicts B.
      miss_fill("A", 37'h828, mkline(1), 30'(wd(1, 0) >> 2));
      miss_fill("B", 37'h1028, mkline(2), 30'(wd(2, 0) >> 2));
      miss_fill("C", 37'h1828, mkline(3), 30'(wd(3, 0) >> 2));
      miss_fill("D", 37'h2028, mkline(4), 30'(wd(4, 0) >> 2));
      hit_chk("C.hit", 37'h1829, 30'(wd(3, 1) >> 2));
      hit_chk("D.hit", 37'h2029, 30'(wd(4, 1) >> 2));

      // A now misses; its fill collides with invalidate and must restart.
      req_valid = 1'b1; req_vaddr = 37'h828;
      step();
      req_valid = 1'b0;
      chk("A2.miss", resp_valid, 0);
      step();
      chk("A2.rreq", refill_req, 1);
      refill_ack = 1'b1; invalidate = 1'b1; refill_data = mkline(1);
      step();
      refill_ack = 1'b0; invalidate = 1'b0;
      step();
      step();
      chk("coll.replay_miss", resp_valid, 0);
      step();
      chk("coll.rreq", refill_req, 1);
      chk("coll.raddr", refill_addr, 34'h105);
      refill_ack = 1'b1;
      step();
      refill_ack = 1'b0;
      step(); step();
      chk("coll.rv", resp_valid, 1);
      chk("coll.word", resp_word, 30'(wd(1, 0) >> 2));
      step();

      // Reset during REQ abandons the refill; a late ack is ignored.
      req_valid = 1'b1; req_vaddr = 37'h400;
      step();
      req_valid = 1'b0;
      step();
      chk("rq.rreq", refill_req, 1);
      reset_n = 1'b0;
      #1;
      chk("rq.rreq_rst", refill_req, 0);
      chk("rq.ready_rst", req_ready, 0);
      step();
      reset_n = 1'b1;
      step();
      chk("rq.ready", req_ready, 1);
      refill_ack = 1'b1; refill_data = mkline(0);
      step();
      refill_ack = 1'b0;
      chk("late.rv", resp_valid, 0);
      chk("late.rreq", refill_req, 0);
      step(); step();
      chk("late.rv2", resp_valid, 0);
      req_valid = 1'b1; req_vaddr = 37'h828;
      step();
      req_valid = 1'b0;
      chk("post.miss", resp_valid, 0);
      step();
      chk("post.rreq", refill_req, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
